// File: rtl/fp_pkg.sv
// Shared floating-point package: FSM state encoding, special-operand classes,
// flag bit positions, exponent bias and canonical NaN helpers.
package fp_pkg;

   typedef enum logic [2:0] {IDLE, MUL, NORM, RND, OUT} state_t;

   // Operand class carried alongside the datapath; overrides the numeric result
   typedef enum logic [1:0] {SP_NONE, SP_ZERO, SP_INF, SP_NAN} special_t;

   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_NX  = 0;

   function automatic int unsigned bias(input int unsigned exp_w);
      return (32'd1 << (exp_w - 1)) - 32'd1;
   endfunction

   // {0, all-ones exponent, quiet bit set, rest zero}; caller truncates to width
   function automatic logic [63:0] canon_nan(input int unsigned exp_w, input int unsigned frac_w);
      return (((64'd1 << exp_w) - 64'd1) << frac_w) | (64'd1 << (frac_w - 1));
   endfunction

endpackage

// File: rtl/fp_mult_iter_if.sv
// Operand/result handshake bundle for the iterative FP multiplier.
interface fp_mult_iter_if #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
);
   localparam int W = 1 + EXP_W + FRAC_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, flags
   );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised mantissa with guard/round/sticky,
// followed by exponent range check (saturate to Inf / flush to zero).
module fp_round_rne
   import fp_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic                      [FRAC_W:0] mant,
   input  logic                                 g,
   input  logic                                 r,
   input  logic                                 s,
   input  logic signed               [EXP_W+1:0] exp_in,
   output logic                      [FRAC_W-1:0] frac_out,
   output logic                      [EXP_W-1:0] exp_out,
   output logic                                 ovf,
   output logic                                 unf,
   output logic                                 nx
);

   localparam int M  = FRAC_W + 1;
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

   logic          inc;
   logic [M:0]    sum;
   logic [M-1:0]  mant_r;
   logic signed [EW-1:0] exp_r;

   // Increment on guard when above half or tied with odd lsb; renormalise on carry-out
   always_comb begin
      inc    = g & (r | s | mant[0]);
      sum    = {1'b0, mant} + (M+1)'(inc);
      mant_r = sum[M-1:0];
      exp_r  = exp_in;
      if (sum[M]) begin
         mant_r = {1'b1, {(M-1){1'b0}}};
         exp_r  = exp_in + EW'(1);
      end
      ovf      = (exp_r >= EXP_MAX);
      unf      = exp_r[EW-1] || (exp_r == '0);
      nx       = g | r | s | ovf | unf;
      frac_out = mant_r[FRAC_W-1:0];
      exp_out  = exp_r[EXP_W-1:0];
   end

endmodule

// File: rtl/fp_mult_iter.sv
// Iterative floating-point multiplier: shift-add mantissa product, normalise,
// RNE rounding, valid/ready on both sides, fixed latency FRAC_W+4.
// Optional macro FP_MULT_SPECIALS_EN enables Inf/NaN decoding of all-ones exponents.
module fp_mult_iter
   import fp_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input logic         clock,
   input logic         reset,
   fp_mult_iter_if.slave bus
);

   localparam int W     = 1 + EXP_W + FRAC_W;
   localparam int M     = FRAC_W + 1;
   localparam int P     = 2 * M;
   localparam int EW    = EXP_W + 2;
   localparam int CNT_W = $clog2(M + 1);
   localparam int unsigned BIAS = bias(EXP_W);

   state_t state, next_state;

   logic [EXP_W-1:0]  a_exp, b_exp;
   logic [FRAC_W-1:0] a_frac, b_frac;
   special_t          sp_in;

   logic                 sign_q;
   logic signed [EW-1:0] exp_q;
   special_t             sp_q;
   logic [P-1:0]         acc;
   logic [P-1:0]         mcand;
   logic [M-1:0]         mplier;
   logic [CNT_W-1:0]     cnt;
   logic [M-1:0]         mant_n;
   logic                 g_n, r_n, s_n;
   logic [W-1:0]         result_q;
   logic [3:0]           flags_q;

   logic [FRAC_W-1:0] rnd_frac;
   logic [EXP_W-1:0]  rnd_exp;
   logic              rnd_ovf, rnd_unf, rnd_nx;
   logic [W-1:0]      pack_result;
   logic [3:0]        pack_flags;
   logic              in_ready_c, out_valid_c;

   assign a_exp  = bus.a[W-2 -: EXP_W];
   assign b_exp  = bus.b[W-2 -: EXP_W];
   assign a_frac = bus.a[FRAC_W-1:0];
   assign b_frac = bus.b[FRAC_W-1:0];

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;

`ifdef FP_MULT_SPECIALS_EN
   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   // Classify operands: NaN and Inf*0 dominate, then Inf, then zero
   always_comb begin
      a_zero = (a_exp == '0);
      b_zero = (b_exp == '0);
      a_inf  = (a_exp == '1) && (a_frac == '0);
      b_inf  = (b_exp == '1) && (b_frac == '0);
      a_nan  = (a_exp == '1) && (a_frac != '0);
      b_nan  = (b_exp == '1) && (b_frac != '0);
      sp_in  = SP_NONE;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         sp_in = SP_NAN;
      else if (a_inf || b_inf)
         sp_in = SP_INF;
      else if (a_zero || b_zero)
         sp_in = SP_ZERO;
   end
`else
   // Zero exponent flushes the operand to zero; all other encodings are finite
   always_comb begin
      sp_in = SP_NONE;
      if ((a_exp == '0) || (b_exp == '0))
         sp_in = SP_ZERO;
   end
`endif

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state and handshake outputs; MUL holds one extra cycle once the count drains
   always_comb begin
      next_state  = state;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) next_state = MUL;
         end
         MUL:  if (cnt == '0) next_state = NORM;
         NORM: next_state = RND;
         RND:  next_state = OUT;
         OUT: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Datapath: capture, shift-add iterations, normalisation, result register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sign_q   <= 1'b0;
         exp_q    <= '0;
         sp_q     <= SP_NONE;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
         mant_n   <= '0;
         g_n      <= 1'b0;
         r_n      <= 1'b0;
         s_n      <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               sign_q <= bus.a[W-1] ^ bus.b[W-1];
               exp_q  <= EW'(a_exp) + EW'(b_exp) - EW'(BIAS);
               sp_q   <= sp_in;
               acc    <= '0;
               mcand  <= P'({1'b1, a_frac});
               mplier <= {1'b1, b_frac};
               cnt    <= CNT_W'(M);
            end
            MUL: if (cnt != '0) begin
               if (mplier[0]) acc <= acc + mcand;
               mplier <= mplier >> 1;
               mcand  <= mcand << 1;
               cnt    <= cnt - CNT_W'(1);
            end
            NORM: begin
               if (acc[P-1]) begin
                  mant_n <= acc[P-1 -: M];
                  g_n    <= acc[M-1];
                  r_n    <= acc[M-2];
                  s_n    <= |acc[M-3:0];
                  exp_q  <= exp_q + EW'(1);
               end else begin
                  mant_n <= acc[P-2 -: M];
                  g_n    <= acc[M-2];
                  r_n    <= acc[M-3];
                  s_n    <= |acc[M-4:0];
               end
            end
            RND: begin
               result_q <= pack_result;
               flags_q  <= pack_flags;
            end
            default: ;
         endcase
      end
   end

   fp_round_rne #(
      .EXP_W  (EXP_W),
      .FRAC_W (FRAC_W)
   ) u_round (
      .mant     (mant_n),
      .g        (g_n),
      .r        (r_n),
      .s        (s_n),
      .exp_in   (exp_q),
      .frac_out (rnd_frac),
      .exp_out  (rnd_exp),
      .ovf      (rnd_ovf),
      .unf      (rnd_unf),
      .nx       (rnd_nx)
   );

   // Final encoding: special classes override the rounded numeric result
   always_comb begin
      pack_result          = {sign_q, rnd_exp, rnd_frac};
      pack_flags           = '0;
      pack_flags[FLG_NX]   = rnd_nx;
      if (rnd_ovf) begin
         pack_result         = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         pack_flags[FLG_OVF] = 1'b1;
      end else if (rnd_unf) begin
         pack_result         = {sign_q, {(W-1){1'b0}}};
         pack_flags[FLG_UNF] = 1'b1;
      end
      case (sp_q)
         SP_ZERO: begin
            pack_result = {sign_q, {(W-1){1'b0}}};
            pack_flags  = '0;
         end
         SP_INF: begin
            pack_result = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            pack_flags  = '0;
         end
         SP_NAN: begin
            pack_result         = W'(canon_nan(EXP_W, FRAC_W));
            pack_flags          = '0;
            pack_flags[FLG_INV] = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fp_mult_iter.sv
// Self-checking bench for fp_mult_iter (single precision build): directed
// corner cases, randomized operands against an integer-arithmetic reference,
// backpressure and mid-operation reset. Honours FP_MULT_SPECIALS_EN.
module tb_fp_mult_iter;

   localparam int EXP_W   = 8;
   localparam int FRAC_W  = 23;
   localparam int LATENCY = FRAC_W + 4;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_fail;

   fp_mult_iter_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) bus ();

   fp_mult_iter #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: exact integer product, RNE by remainder comparison against one half
   task automatic model(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [3:0] fl);
      logic              s;
      int                ea, eb, e, shift;
      longint unsigned   ma, mb, p, mant, rem, half;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
`ifdef FP_MULT_SPECIALS_EN
      if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
          (ea == 255 && eb == 0) || (eb == 255 && ea == 0)) begin
         res = 32'h7FC00000; fl = 4'b1000; return;
      end
      if (ea == 255 || eb == 255) begin
         res = {s, 8'hFF, 23'd0}; fl = 4'b0000; return;
      end
`endif
      if (ea == 0 || eb == 0) begin
         res = {s, 31'd0}; fl = 4'b0000; return;
      end
      ma = 64'(a[22:0]) | (64'd1 << 23);
      mb = 64'(b[22:0]) | (64'd1 << 23);
      p  = ma * mb;
      e  = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin shift = 24; e++; end
      else shift = 23;
      mant = p >> shift;
      rem  = p - (mant << shift);
      half = 64'd1 << (shift - 1);
      if (rem > half || (rem == half && mant[0])) mant++;
      if (mant == (64'd1 << 24)) begin mant = mant >> 1; e++; end
      if (e >= 255) begin
         res = {s, 8'hFF, 23'd0}; fl = 4'b0101;
      end else if (e <= 0) begin
         res = {s, 31'd0}; fl = 4'b0011;
      end else begin
         res = {s, e[7:0], mant[22:0]}; fl = {3'b000, rem != 0};
      end
   endtask

   // Present operands, then count clocks until out_valid (noise on in_valid while busy)
   task automatic start_and_wait(input logic [31:0] opa, input logic [31:0] opb,
                                 input bit noise, output int cyc, output bit got);
      @(negedge clock);
      check("in_ready_idle", bus.in_ready, 1);
      bus.a = opa; bus.b = opb; bus.in_valid = 1'b1;
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
      cyc = 0; got = 0;
      while (!got && cyc < 100) begin
         if (noise) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a = $urandom; bus.b = $urandom;
         end
         @(posedge clock);
         #1;
         cyc++;
         if (bus.out_valid) got = 1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clock);
      #1;
      bus.out_ready = 1'b0;
      check({tag, "_in_ready_after"}, bus.in_ready, 1);
      check({tag, "_out_valid_after"}, bus.out_valid, 0);
   endtask

   task automatic run_op(input logic [31:0] opa, input logic [31:0] opb,
                         input string tag, input bit noise);
      logic [31:0] er;
      logic [3:0]  ef;
      int          cyc;
      bit          got;
      model(opa, opb, er, ef);
      start_and_wait(opa, opb, noise, cyc, got);
      check({tag, "_latency"}, cyc, LATENCY);
      if (got) begin
         check({tag, "_result"}, bus.result, er);
         check({tag, "_flags"}, bus.flags, ef);
         drain(tag);
      end
   endtask

   function automatic logic [31:0] rand_operand();
      logic [7:0]  e;
      logic [22:0] f;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel < 6)       e = 8'($urandom_range(100, 154));
      else if (sel == 6) e = 8'd0;
      else if (sel == 7) e = 8'($urandom_range(200, 254));
      else if (sel == 8) e = 8'($urandom_range(1, 30));
      else               e = 8'($urandom_range(0, 255));
      f = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
      return {1'($urandom), e, f};
   endfunction

   initial begin
      logic [31:0] er;
      logic [3:0]  ef;
      logic [31:0] held_r;
      logic [3:0]  held_f;
      int          cyc;
      int          ghost;
      bit          got;

      n_checks = 0;
      n_fail   = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;
      reset = 1'b1;
      #2;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_result", bus.result, 0);
      check("rst_flags", bus.flags, 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      run_op(32'h3F800000, 32'h3F800000, "one_x_one", 0);
      run_op(32'hC0000000, 32'h40400000, "m2_x_3", 0);
      run_op(32'h3F800001, 32'h3F800001, "rne_nx", 0);
      run_op(32'h7F000000, 32'h7F000000, "overflow", 0);
      run_op(32'h00800000, 32'h3F000000, "underflow", 0);
      run_op(32'h80000000, 32'h3F800000, "neg_zero", 0);
      run_op(32'h3FFFFFFF, 32'h3FFFFFFF, "carry_out", 0);
`ifdef FP_MULT_SPECIALS_EN
      run_op(32'h7F800000, 32'h00000000, "inf_x_zero", 0);
      run_op(32'hFF800000, 32'h40000000, "inf_x_two", 0);
      run_op(32'h7FC00001, 32'h3F800000, "nan_in", 0);
`else
      run_op(32'h7F800000, 32'h3F800000, "allones_finite", 0);
`endif

      // Backpressure: result and flags held, in_valid pulses ignored
      model(32'h40490FDB, 32'h402DF854, er, ef);
      start_and_wait(32'h40490FDB, 32'h402DF854, 0, cyc, got);
      check("bp_latency", cyc, LATENCY);
      held_r = bus.result;
      held_f = bus.flags;
      check("bp_result", held_r, er);
      check("bp_flags", held_f, ef);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.a = $urandom; bus.b = $urandom;
         @(posedge clock);
         #1;
         check("bp_hold_valid", bus.out_valid, 1);
         check("bp_hold_result", bus.result, er);
         check("bp_hold_flags", bus.flags, ef);
      end
      bus.in_valid = 1'b0;
      if (got) drain("bp");
      run_op(32'h41200000, 32'hC1200000, "after_bp", 0);

      // Reset in the middle of the iteration phase aborts the operation
      @(negedge clock);
      bus.a = 32'h40000000; bus.b = 32'h40000000; bus.in_valid = 1'b1;
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_out_valid", bus.out_valid, 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      ghost = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (bus.out_valid) ghost++;
      end
      check("midrst_no_ghost", ghost, 0);
      check("midrst_in_ready_after", bus.in_ready, 1);
      run_op(32'h40000000, 32'h40400000, "after_rst", 0);

      // Randomized operands, with in_valid noise while busy on half of them
      for (int i = 0; i < 60; i++)
         run_op(rand_operand(), rand_operand(), "rand", (i % 2) == 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
